// File: rtl/axi_wbeat_gen_pkg.sv
// Shared types for the AXI write-beat generator: burst length type and FSM states.
package axi_pkg;

  localparam int AXI_LW = 8;

  typedef logic [AXI_LW-1:0] axi_len_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } wgen_state_e;

endpackage

// File: rtl/axi_wbeat_gen_reg_slice2.sv
// Two-entry registered skid buffer; in_ready depends only on registered occupancy.
module reg_slice2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign count     = cnt_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= in_data;
          else               tail_q <= in_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        // Simultaneous push/pop only happens with one entry held (full blocks push).
        2'b11: head_q <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_wbeat_gen.sv
// AXI W-channel beat generator: pops len+1 words from the afifo read side per command
// and drives them as one W burst through a two-entry skid buffer.
module axi_wbeat_gen
  import axi_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 4,
  parameter int LW        = 8,
  parameter int STORE_FWD = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [LW-1:0]   cmd_len,
  input  logic            fifo_rempty,
  input  logic [AW:0]     fifo_rcnt,
  input  logic [DW-1:0]   fifo_q,
  output logic            fifo_re,
  output logic            wvalid,
  input  logic            wready,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wlast,
  output logic            busy,
  output wgen_state_e     dbg_state
);

  // Handshakes (cmd, W): a transfer occurs on the clk edge where valid && ready are both
  // high; once valid is raised it is held, with payload stable, until that transfer.

  localparam int CW = ((LW > AW) ? LW : AW) + 1;
  localparam logic [LW:0]   ONE   = {{LW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] DEPTH = {{(CW-1){1'b0}}, 1'b1} << AW;

  wgen_state_e    state_q, state_d;
  logic [LW:0]    pop_left_q;
  logic [CW-1:0]  thr_q;
  logic [LW:0]    len_p1;
  logic [CW-1:0]  len_p1_ext;
  logic [CW-1:0]  rcnt_ext;
  logic           skid_in_ready;
  logic [1:0]     skid_cnt;

  assign len_p1     = {1'b0, cmd_len} + ONE;
  assign len_p1_ext = CW'(len_p1);
  assign rcnt_ext   = CW'(fifo_rcnt);

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    fifo_re   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (STORE_FWD != 0) ? WAIT : XFER;
      end
      WAIT: begin
        if (rcnt_ext >= thr_q) state_d = XFER;
      end
      XFER: begin
        // skid_in_ready is registered occupancy, so wready never reaches fifo_re.
        fifo_re = !fifo_rempty && (pop_left_q != '0) && skid_in_ready;
        if (wvalid && wready && wlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pop_left_q <= '0;
      thr_q      <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_valid && cmd_ready) begin
        pop_left_q <= len_p1;
        thr_q      <= (len_p1_ext > DEPTH) ? DEPTH : len_p1_ext;
      end else if (fifo_re) begin
        pop_left_q <= pop_left_q - ONE;
      end
    end
  end

  reg_slice2 #(.W(DW + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (fifo_re),
    .in_ready  (skid_in_ready),
    .in_data   ({(pop_left_q == ONE), fifo_q}),
    .out_valid (wvalid),
    .out_ready (wready),
    .out_data  ({wlast, wdata}),
    .count     (skid_cnt)
  );

  assign wstrb     = '1;
  assign busy      = (state_q != IDLE) || (skid_cnt != 2'd0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_axi_wbeat_gen.sv
// Bench for axi_wbeat_gen: a store-and-forward and a streaming instance share one FIFO
// model and one scoreboard; sel chooses which instance is connected.
`timescale 1ns/1ps
module tb_axi_wbeat_gen;
  import axi_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int LW    = 8;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus and muxed DUT view ----------------
  logic            sel;          // 0: STORE_FWD=1 instance, 1: STORE_FWD=0 instance
  logic            cmd_valid;
  logic [LW-1:0]   cmd_len;
  logic            wready;
  logic            fifo_rempty;
  logic [AW:0]     fifo_rcnt;
  logic [DW-1:0]   fifo_q;

  logic            cmd_ready_d [2];
  logic            fifo_re_d   [2];
  logic            wvalid_d    [2];
  logic            wlast_d     [2];
  logic            busy_d      [2];
  logic [DW-1:0]   wdata_d     [2];
  logic [DW/8-1:0] wstrb_d     [2];
  wgen_state_e     st_d        [2];

  logic            cmd_ready, fifo_re, wvalid, wlast, busy;
  logic [DW-1:0]   wdata;

  assign cmd_ready = sel ? cmd_ready_d[1] : cmd_ready_d[0];
  assign fifo_re   = sel ? fifo_re_d[1]   : fifo_re_d[0];
  assign wvalid    = sel ? wvalid_d[1]    : wvalid_d[0];
  assign wlast     = sel ? wlast_d[1]     : wlast_d[0];
  assign busy      = sel ? busy_d[1]      : busy_d[0];
  assign wdata     = sel ? wdata_d[1]     : wdata_d[0];

  axi_wbeat_gen #(.DW(DW), .AW(AW), .LW(LW), .STORE_FWD(1)) dut_sf (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid && !sel), .cmd_ready(cmd_ready_d[0]), .cmd_len(cmd_len),
    .fifo_rempty(fifo_rempty || sel), .fifo_rcnt(sel ? '0 : fifo_rcnt), .fifo_q(fifo_q),
    .fifo_re(fifo_re_d[0]), .wvalid(wvalid_d[0]), .wready(wready && !sel),
    .wdata(wdata_d[0]), .wstrb(wstrb_d[0]), .wlast(wlast_d[0]), .busy(busy_d[0]),
    .dbg_state(st_d[0])
  );

  axi_wbeat_gen #(.DW(DW), .AW(AW), .LW(LW), .STORE_FWD(0)) dut_st (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid && sel), .cmd_ready(cmd_ready_d[1]), .cmd_len(cmd_len),
    .fifo_rempty(fifo_rempty || !sel), .fifo_rcnt(sel ? fifo_rcnt : '0), .fifo_q(fifo_q),
    .fifo_re(fifo_re_d[1]), .wvalid(wvalid_d[1]), .wready(wready && sel),
    .wdata(wdata_d[1]), .wstrb(wstrb_d[1]), .wlast(wlast_d[1]), .busy(busy_d[1]),
    .dbg_state(st_d[1])
  );

  // ---------------- reference model state ----------------
  logic [DW-1:0] fifo_mem [$];   // words held by the afifo
  logic [DW-1:0] src_q    [$];   // words not yet written into the afifo
  logic [DW:0]   exp_q    [$];   // expected {wlast, wdata} beats in order
  int fill_gap   = 1;
  int fill_timer = 0;
  int wr_mode    = 3;            // 0: ready=1, 1: toggle, 2: random, 3: ready=0

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int cyc   = 0;

  logic burst_active  = 1'b0;
  logic gate_seen     = 1'b0;
  logic prev_stall    = 1'b0;
  logic last_hs_prev  = 1'b0;
  logic [DW:0] prev_beat = '0;
  int burst_len = 0;
  int thr = 0;
  int beats = 0;
  int first_pop_cyc = -1;
  int first_wv_cyc  = -1;
  int first_beat_cyc = 0;
  int last_beat_cyc  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_rempty = (fifo_mem.size() == 0);
    fifo_rcnt   = (AW+1)'(fifo_mem.size());
    fifo_q      = (fifo_mem.size() != 0) ? fifo_mem[0] : '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_words(input int len);
    logic [DW-1:0] w;
    for (int i = 0; i <= len; i++) begin
      w = $urandom;
      src_q.push_back(w);
      exp_q.push_back({(i == len), w});
    end
  endtask

  task automatic send_cmd(input int len);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    n = 0;
    while (n < 4000) begin
      #4;
      if (cmd_ready) break;
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_accept", 64'(n < 4000), 64'(1));
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 4000 && !(exp_q.size() == 0 && src_q.size() == 0 && fifo_mem.size() == 0
                         && !busy && !burst_active)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(n < 4000), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  initial begin : wready_drv
    wready = 1'b0;
    forever begin
      @(negedge clk);
      case (wr_mode)
        0:       wready = 1'b1;
        1:       wready = ~wready;
        2:       wready = 1'($urandom_range(0, 1));
        default: wready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard / FIFO model ----------------
  logic          s_rst, s_re, s_wv, s_wr, s_last, s_cr, s_cv;
  logic [DW-1:0] s_data;
  logic [LW-1:0] s_len;
  logic [AW:0]   s_rcnt;
  logic [DW:0]   exp_b;

  initial begin : monitor
    forever begin
      @(negedge clk); #4;
      s_rst = reset;  s_re = fifo_re;  s_wv = wvalid;  s_wr = wready;
      s_last = wlast; s_data = wdata;  s_cr = cmd_ready; s_cv = cmd_valid;
      s_len = cmd_len; s_rcnt = fifo_rcnt;
      @(posedge clk); #1;
      cyc++;
      if (s_rst) begin
        burst_active = 1'b0;
        prev_stall   = 1'b0;
        last_hs_prev = 1'b0;
      end else begin
        if (last_hs_prev) chk("cmd_ready_after_last", 64'(s_cr), 64'(1));
        last_hs_prev = 1'b0;
        if (prev_stall) begin
          chk("wvalid_held", 64'(s_wv), 64'(1));
          chk("beat_stable", 64'({s_last, s_data}), 64'(prev_beat));
        end
        if (s_re) begin
          pops++;
          chk("pop_has_cmd", 64'(burst_active), 64'(1));
          if (sel == 1'b0) chk("pop_after_gate", 64'(gate_seen), 64'(1));
          if (burst_active && first_pop_cyc < 0) first_pop_cyc = cyc;
          chk("pop_nonempty", 64'(fifo_mem.size() != 0), 64'(1));
          if (fifo_mem.size() != 0) void'(fifo_mem.pop_front());
        end
        if (s_wv && burst_active && first_wv_cyc < 0) begin
          first_wv_cyc = cyc;
          chk("first_wvalid_latency", 64'(cyc - first_pop_cyc), 64'(1));
        end
        if (s_wv && s_wr) begin
          if (beats == 0) first_beat_cyc = cyc;
          last_beat_cyc = cyc;
          beats++;
          chk("beat_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            chk("beat", 64'({s_last, s_data}), 64'(exp_b));
          end
          if (s_last) begin
            chk("beats_in_burst", 64'(beats), 64'(burst_len));
            burst_active = 1'b0;
            last_hs_prev = 1'b1;
          end
        end
        prev_stall = s_wv && !s_wr;
        prev_beat  = {s_last, s_data};
        if (burst_active && int'(s_rcnt) >= thr) gate_seen = 1'b1;
        if (s_cv && s_cr) begin
          burst_active  = 1'b1;
          burst_len     = int'(s_len) + 1;
          thr           = (burst_len < DEPTH) ? burst_len : DEPTH;
          gate_seen     = 1'b0;
          beats         = 0;
          first_pop_cyc = -1;
          first_wv_cyc  = -1;
        end
        if (src_q.size() != 0 && fifo_mem.size() < DEPTH) begin
          fill_timer++;
          if (fill_timer >= fill_gap) begin
            fifo_mem.push_back(src_q.pop_front());
            fill_timer = 0;
          end
        end
      end
      drive_fifo();
    end
  end

  // ---------------- stimulus ----------------
  int mark;
  int len_r;

  initial begin : stim
    reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
    drive_fifo();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_cmd_ready", 64'(cmd_ready_d[d]), 64'(1));
      chk("rst_wvalid",    64'(wvalid_d[d]),    64'(0));
      chk("rst_wlast",     64'(wlast_d[d]),     64'(0));
      chk("rst_wdata",     64'(wdata_d[d]),     64'(0));
      chk("rst_busy",      64'(busy_d[d]),      64'(0));
      chk("rst_fifo_re",   64'(fifo_re_d[d]),   64'(0));
      chk("rst_wstrb",     64'(wstrb_d[d]),     64'(4'hF));
      chk("rst_state",     64'(st_d[d]),        64'(IDLE));
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // store-and-forward, slow fill, free-flowing W
    sel = 1'b0; fill_gap = 4; wr_mode = 0; mark = pops;
    load_words(3); send_cmd(3); wait_done("sf_len3");
    chk("sf_len3_pops", 64'(pops - mark), 64'(4));
    chk("sf_len3_back_to_back", 64'(last_beat_cyc - first_beat_cyc), 64'(3));

    // streaming, FIFO prefilled, W ready toggling
    sel = 1'b1; fill_gap = 1; wr_mode = 3; mark = pops;
    load_words(7);
    repeat (12) @(negedge clk);
    chk("st_prefill", 64'(fifo_rcnt), 64'(8));
    wr_mode = 1;
    send_cmd(7); wait_done("st_len7");
    chk("st_len7_pops", 64'(pops - mark), 64'(8));

    // single-beat bursts and back-to-back commands on both instances
    for (int d = 0; d < 2; d++) begin
      sel = 1'(d); wr_mode = 0; fill_gap = 1; mark = pops;
      load_words(0); send_cmd(0); wait_done("len0");
      chk("len0_pops", 64'(pops - mark), 64'(1));
      mark = pops;
      load_words(1); load_words(2);
      send_cmd(1); send_cmd(2); wait_done("b2b");
      chk("b2b_pops", 64'(pops - mark), 64'(5));
    end

    // longest burst: threshold saturates at FIFO depth
    sel = 1'b0; fill_gap = 1; wr_mode = 2; mark = pops;
    load_words(255); send_cmd(255); wait_done("len255");
    chk("len255_pops", 64'(pops - mark), 64'(256));

    // random bursts
    for (int r = 0; r < 6; r++) begin
      len_r = $urandom_range(0, 40);
      sel = 1'($urandom_range(0, 1));
      fill_gap = $urandom_range(1, 3);
      wr_mode = 2; mark = pops;
      load_words(len_r); send_cmd(len_r); wait_done("rand");
      chk("rand_pops", 64'(pops - mark), 64'(len_r + 1));
    end

    // asynchronous reset while a burst is stalled
    sel = 1'b0; fill_gap = 1; wr_mode = 3;
    load_words(15); send_cmd(15);
    repeat (25) @(negedge clk);
    chk("mid_burst_wvalid", 64'(wvalid_d[0]), 64'(1));
    @(posedge clk); #3;
    reset = 1'b1; #1;
    chk("mid_rst_wvalid",    64'(wvalid_d[0]),    64'(0));
    chk("mid_rst_cmd_ready", 64'(cmd_ready_d[0]), 64'(1));
    chk("mid_rst_busy",      64'(busy_d[0]),      64'(0));
    chk("mid_rst_fifo_re",   64'(fifo_re_d[0]),   64'(0));
    fifo_mem.delete(); src_q.delete(); exp_q.delete();
    drive_fifo();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) fifo_mem.push_back($urandom);
    drive_fifo();
    mark = pops;
    repeat (10) @(negedge clk);
    chk("no_pop_after_reset", 64'(pops - mark), 64'(0));
    fifo_mem.delete();
    drive_fifo();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
